// File: rtl/array_uart_tx.sv
// Snapshots the six result-array bytes on a start pulse and sends them (plus an
// optional trailing newline) as back-to-back 8N1 UART frames.
module array_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SEND_NEWLINE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] Arr1,
    input  logic [7:0] Arr2,
    input  logic [7:0] Arr3,
    input  logic [7:0] Arr4,
    input  logic [7:0] Arr5,
    input  logic [7:0] Arr6,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int              BW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_MAX   = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_FRAME = 3'(5 + SEND_NEWLINE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [BW-1:0]   baud_cnt_r;
    logic [BW-1:0]   baud_cnt_nxt_s;
    logic [2:0]      bit_idx_r;
    logic [2:0]      bit_idx_nxt_s;
    logic [2:0]      byte_idx_r;
    logic [2:0]      byte_idx_nxt_s;
    logic [7:0]      shadow_r [0:5];
    logic [7:0]      frame_byte_s;
    logic            load_s;
    logic            done_nxt_s;
    logic            tx_nxt_s;
    logic            baud_last_s;
    logic            tx_r;
    logic            busy_r;
    logic            done_r;

    assign baud_last_s = (baud_cnt_r == BAUD_MAX);

    // Next-state, counter and control decode for the frame sequencer
    always_comb begin
        state_nxt_s    = state_r;
        baud_cnt_nxt_s = baud_cnt_r;
        bit_idx_nxt_s  = bit_idx_r;
        byte_idx_nxt_s = byte_idx_r;
        load_s         = 1'b0;
        done_nxt_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                baud_cnt_nxt_s = '0;
                bit_idx_nxt_s  = 3'd0;
                if (start) begin
                    state_nxt_s    = S_START;
                    byte_idx_nxt_s = 3'd0;
                    load_s         = 1'b1;
                end else begin
                    state_nxt_s    = S_IDLE;
                end
            end
            S_START: begin
                if (baud_last_s) begin
                    baud_cnt_nxt_s = '0;
                    bit_idx_nxt_s  = 3'd0;
                    state_nxt_s    = S_DATA;
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last_s) begin
                    baud_cnt_nxt_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_nxt_s = 3'd0;
                        state_nxt_s   = S_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_last_s) begin
                    baud_cnt_nxt_s = '0;
                    if (byte_idx_r < LAST_FRAME) begin
                        byte_idx_nxt_s = byte_idx_r + 3'd1;
                        state_nxt_s    = S_START;
                    end else begin
                        state_nxt_s = S_IDLE;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BW'(1);
                end
            end
            default: begin
                state_nxt_s    = S_IDLE;
                baud_cnt_nxt_s = '0;
                bit_idx_nxt_s  = 3'd0;
                byte_idx_nxt_s = 3'd0;
            end
        endcase
    end

    // Byte for the frame about to be on the line; frame 6 is the newline
    always_comb begin
        frame_byte_s = 8'h0A;
        case (byte_idx_nxt_s)
            3'd0:    frame_byte_s = shadow_r[0];
            3'd1:    frame_byte_s = shadow_r[1];
            3'd2:    frame_byte_s = shadow_r[2];
            3'd3:    frame_byte_s = shadow_r[3];
            3'd4:    frame_byte_s = shadow_r[4];
            3'd5:    frame_byte_s = shadow_r[5];
            3'd6:    frame_byte_s = 8'h0A;
            default: frame_byte_s = 8'h0A;
        endcase
    end

    // Line level follows the upcoming state so tx can be a plain register
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            S_IDLE:  tx_nxt_s = 1'b1;
            S_START: tx_nxt_s = 1'b0;
            S_DATA:  tx_nxt_s = frame_byte_s[bit_idx_nxt_s];
            S_STOP:  tx_nxt_s = 1'b1;
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 3'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            byte_idx_r <= byte_idx_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
            done_r     <= done_nxt_s;
        end
    end

    // Snapshot of the array bytes, taken only when a start is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else if (load_s) begin
            shadow_r[0] <= Arr1;
            shadow_r[1] <= Arr2;
            shadow_r[2] <= Arr3;
            shadow_r[3] <= Arr4;
            shadow_r[4] <= Arr5;
            shadow_r[5] <= Arr6;
        end else begin
            for (int i = 0; i < 6; i++) begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
